// File: rtl/nn_sequencer.sv
// nn_sequencer: control FSM driving hidden/output neuron passes and ArgMax per sample.
// Optional feature macro NN_SEQ_ACCURACY_EN adds label input and correct_count output.
module nn_sequencer #(
  parameter int NUM_SAMPLES    = 750,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  ready_vec,
  input  logic [4:0]  max_index,
`ifdef NN_SEQ_ACCURACY_EN
  input  logic [3:0]  label,
  output logic [10:0] correct_count,
`endif
  output logic        startNeurons,
  output logic [1:0]  ctrl_w_b_data_neuron,
  output logic        ld_regs1,
  output logic        ld_regs2,
  output logic        enMax,
  output logic [10:0] dataGroupNumber,
  output logic        result_valid,
  output logic [4:0]  result_index,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_H1_GO, S_H1_WAIT, S_H1_LD,
    S_H2_GO, S_H2_WAIT, S_H2_LD, S_O_GO,
    S_O_WAIT, S_AMAX, S_RES, S_DONE, S_ERR
  } state_t;

  localparam logic [10:0]   LP_LAST = 11'(NUM_SAMPLES - 1);
  localparam logic [TO_W:0] LP_TO   = (TO_W + 1)'(TIMEOUT_CYCLES);

  state_t          r_state;
  state_t          w_next;
  logic [10:0]     r_dgn;
  logic [4:0]      r_res;
  logic [TO_W-1:0] r_to;
  logic [TO_W:0]   w_to_inc;
  logic            w_wait;
  logic            w_adv;
  logic            w_limit;
  logic            w_launch;
  logic            w_last;

  // r_to == 0 marks the guard cycle right after a launch pulse
  assign w_to_inc = {1'b0, r_to} + (TO_W + 1)'(1);
  assign w_limit  = w_to_inc >= LP_TO;
  assign w_adv    = (&ready_vec) && (r_to != '0);
  assign w_last   = r_dgn == LP_LAST;
  assign w_wait   = (r_state == S_H1_WAIT) || (r_state == S_H2_WAIT) ||
                    (r_state == S_O_WAIT);
  assign w_launch = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    startNeurons         = 1'b0;
    ld_regs1             = 1'b0;
    ld_regs2             = 1'b0;
    enMax                = 1'b0;
    result_valid         = 1'b0;
    ctrl_w_b_data_neuron = 2'b00;
    busy                 = 1'b1;
    done                 = 1'b0;
    error                = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_H1_GO;
      end
      S_H1_GO: begin
        startNeurons = 1'b1;
        w_next       = S_H1_WAIT;
      end
      S_H1_WAIT: begin
        if (w_adv)        w_next = S_H1_LD;
        else if (w_limit) w_next = S_ERR;
      end
      S_H1_LD: begin
        ld_regs1 = 1'b1;
        w_next   = S_H2_GO;
      end
      S_H2_GO: begin
        ctrl_w_b_data_neuron = 2'b01;
        startNeurons         = 1'b1;
        w_next               = S_H2_WAIT;
      end
      S_H2_WAIT: begin
        ctrl_w_b_data_neuron = 2'b01;
        if (w_adv)        w_next = S_H2_LD;
        else if (w_limit) w_next = S_ERR;
      end
      S_H2_LD: begin
        ctrl_w_b_data_neuron = 2'b01;
        ld_regs2             = 1'b1;
        w_next               = S_O_GO;
      end
      S_O_GO: begin
        ctrl_w_b_data_neuron = 2'b10;
        startNeurons         = 1'b1;
        w_next               = S_O_WAIT;
      end
      S_O_WAIT: begin
        ctrl_w_b_data_neuron = 2'b10;
        if (w_adv)        w_next = S_AMAX;
        else if (w_limit) w_next = S_ERR;
      end
      S_AMAX: begin
        ctrl_w_b_data_neuron = 2'b10;
        enMax                = 1'b1;
        w_next               = S_RES;
      end
      S_RES: begin
        ctrl_w_b_data_neuron = 2'b10;
        result_valid         = 1'b1;
        w_next               = w_last ? S_DONE : S_H1_GO;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_next = S_H1_GO;
      end
      S_ERR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dgn <= '0;
      r_res <= '0;
      r_to  <= '0;
    end else begin
      r_to <= w_wait ? w_to_inc[TO_W-1:0] : '0;
      if (w_launch)
        r_dgn <= '0;
      else if ((r_state == S_RES) && !w_last)
        r_dgn <= r_dgn + 11'd1;
      if (r_state == S_AMAX) r_res <= max_index;
    end
  end

  assign dataGroupNumber = r_dgn;
  assign result_index    = r_res;

`ifdef NN_SEQ_ACCURACY_EN
  logic [3:0]  r_label;
  logic [10:0] r_cc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_label <= '0;
      r_cc    <= '0;
    end else begin
      if (r_state == S_AMAX) r_label <= label;
      if (w_launch)
        r_cc <= '0;
      else if ((r_state == S_RES) && (r_res == {1'b0, r_label}) &&
               (r_cc != 11'h7FF))
        r_cc <= r_cc + 11'd1;
    end
  end

  assign correct_count = r_cc;
`endif

endmodule
